// File: rtl/alu_muldiv_ctrl_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide sequencer.
package alu_muldiv_ctrl_pkg;

  localparam int unsigned DataW   = 32;
  localparam int unsigned MdIters = 32;
  localparam int unsigned CntW    = $clog2(MdIters);

  // ALU function codes; the sequencer only ever issues these two.
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;

  typedef enum logic [2:0] {
    StIdle,
    StPrepA,
    StPrepB,
    StIter,
    StFix0,
    StFix1,
    StFix2,
    StDone
  } md_state_e;

endpackage

// File: rtl/alu_muldiv_ctrl_if.sv
// Request/result bundle between the EX stage and the multiply/divide sequencer.
interface alu_muldiv_ctrl_if;
  import alu_muldiv_ctrl_pkg::*;

  logic             start;
  logic             op_div;
  logic             op_signed;
  logic [DataW-1:0] opa;
  logic [DataW-1:0] opb;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [DataW-1:0] hi;
  logic [DataW-1:0] lo;

  modport master (
    output start, op_div, op_signed, opa, opb,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op_div, op_signed, opa, opb,
    output busy, done, div_by_zero, hi, lo
  );

endinterface

// File: rtl/alu_muldiv_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer that borrows the shared EX-stage ALU.
// Shift-add multiply / restoring divide on magnitudes, with sign fix-up afterwards.
module alu_muldiv_ctrl
  import alu_muldiv_ctrl_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  alu_muldiv_ctrl_if.slave   bus,
  output logic               alu_own_o,
  output logic [DataW-1:0]   alu_rs_o,
  output logic [DataW-1:0]   alu_rt_o,
  output logic [5:0]         alu_funct_o,
  input  logic [DataW:0]     alu_res_i
);

  md_state_e        state_q;
  logic             op_div_q, op_signed_q, neg_a_q, neg_b_q, lo_nz_q;
  logic [DataW-1:0] opa_q, opb_q;   // multiplicand/dividend, multiplier/divisor
  logic [DataW-1:0] acc_q, wlo_q;   // working {hi,lo}: product or {rem,quo}
  logic [DataW-1:0] hi_q, lo_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q, done_q, dbz_q, own_q;

  logic [DataW-1:0] res;
  logic [DataW-1:0] rem_shl, quo_shl, opa_mag, opb_mag;
  logic [DataW-1:0] iter_acc, iter_lo, fix2_acc;
  logic [DataW:0]   mul_sum;
  logic             prod_neg;

  assign res      = alu_res_i[DataW-1:0];
  assign rem_shl  = {acc_q[DataW-2:0], wlo_q[DataW-1]};
  assign quo_shl  = {wlo_q[DataW-2:0], 1'b0};
  assign opa_mag  = opa_q[DataW-1] ? res : opa_q;
  assign opb_mag  = opb_q[DataW-1] ? res : opb_q;
  assign prod_neg = neg_a_q ^ neg_b_q;
  // Only a negated multiply with a nonzero low word needs the borrow into hi.
  assign fix2_acc = (!op_div_q && prod_neg && lo_nz_q) ? res : acc_q;

  // ALU operand/function drive; parked at reset values whenever not owned.
  always_comb begin
    alu_rs_o    = '0;
    alu_rt_o    = '0;
    alu_funct_o = FnAdd;
    if (own_q) begin
      unique case (state_q)
        StPrepA: begin alu_funct_o = FnSub; alu_rt_o = opa_q; end
        StPrepB: begin alu_funct_o = FnSub; alu_rt_o = opb_q; end
        StIter: begin
          if (op_div_q) begin
            alu_funct_o = FnSub;
            alu_rs_o    = rem_shl;
            alu_rt_o    = opb_q;
          end else begin
            alu_rs_o    = acc_q;
            alu_rt_o    = opa_q;
          end
        end
        StFix0:  begin alu_funct_o = FnSub; alu_rt_o = wlo_q; end
        StFix1:  begin alu_funct_o = FnSub; alu_rt_o = acc_q; end
        StFix2:  begin alu_funct_o = FnSub; alu_rs_o = acc_q; alu_rt_o = DataW'(1); end
        default: ;
      endcase
    end
  end

  // One iteration step of shift-add multiply or restoring divide.
  always_comb begin
    mul_sum = wlo_q[0] ? alu_res_i : {1'b0, acc_q};
    if (op_div_q) begin
      // The shifted-out bit means the partial remainder already exceeds any divisor.
      if (acc_q[DataW-1] || !alu_res_i[DataW]) begin
        iter_acc = res;
        iter_lo  = {wlo_q[DataW-2:0], 1'b1};
      end else begin
        iter_acc = rem_shl;
        iter_lo  = quo_shl;
      end
    end else begin
      iter_acc = mul_sum[DataW:1];
      iter_lo  = {mul_sum[0], wlo_q[DataW-1:1]};
    end
  end

  // Sequencer FSM with its datapath and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      op_div_q    <= 1'b0;
      op_signed_q <= 1'b0;
      neg_a_q     <= 1'b0;
      neg_b_q     <= 1'b0;
      lo_nz_q     <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      acc_q       <= '0;
      wlo_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      own_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
          if (bus.start) begin
            op_div_q    <= bus.op_div;
            op_signed_q <= bus.op_signed;
            opa_q       <= bus.opa;
            opb_q       <= bus.opb;
            neg_a_q     <= 1'b0;
            neg_b_q     <= 1'b0;
            acc_q       <= '0;
            wlo_q       <= bus.op_div ? bus.opa : bus.opb;
            cnt_q       <= '0;
            if (bus.op_div && bus.opb == '0) begin
              state_q <= StDone;
              hi_q    <= bus.opa;
              lo_q    <= '1;
              done_q  <= 1'b1;
              dbz_q   <= 1'b1;
            end else begin
              state_q <= bus.op_signed ? StPrepA : StIter;
              dbz_q   <= 1'b0;
              busy_q  <= 1'b1;
              own_q   <= 1'b1;
            end
          end
        end
        StPrepA: begin
          neg_a_q <= opa_q[DataW-1];
          opa_q   <= opa_mag;
          state_q <= StPrepB;
        end
        StPrepB: begin
          neg_b_q <= opb_q[DataW-1];
          opb_q   <= opb_mag;
          wlo_q   <= op_div_q ? opa_q : opb_mag;
          state_q <= StIter;
        end
        StIter: begin
          acc_q <= iter_acc;
          wlo_q <= iter_lo;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(MdIters - 1)) begin
            if (op_signed_q) begin
              state_q <= StFix0;
            end else begin
              state_q <= StDone;
              hi_q    <= iter_acc;
              lo_q    <= iter_lo;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              own_q   <= 1'b0;
            end
          end
        end
        StFix0: begin
          lo_nz_q <= |wlo_q;
          if (prod_neg) wlo_q <= res;
          state_q <= StFix1;
        end
        StFix1: begin
          if (op_div_q ? neg_a_q : prod_neg) acc_q <= res;
          state_q <= StFix2;
        end
        StFix2: begin
          acc_q   <= fix2_acc;
          hi_q    <= fix2_acc;
          lo_q    <= wlo_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          own_q   <= 1'b0;
          state_q <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign alu_own_o       = own_q;

endmodule
